// File: rtl/tmvp_pkg.sv
// Shared constants and the output word layout for the TMVP coefficient packer.
// The packer parameters default to these values.
package tmvp_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int REAL_N     = 509;
    localparam int LANES      = 4;

    localparam int WORDS_PER_FRAME = (REAL_N + LANES - 1) / LANES;

    // Low (real_n mod lanes) bits set, or every lane when the frame divides evenly.
    function automatic int unsigned keep_mask(input int real_n, input int lanes);
        int rem;
        rem = real_n % lanes;
        return (rem == 0) ? ((32'd1 << lanes) - 32'd1) : ((32'd1 << rem) - 32'd1);
    endfunction

    localparam logic [LANES-1:0] LAST_KEEP = LANES'(keep_mask(REAL_N, LANES));

    typedef struct packed {
        logic [LANES*DATA_WIDTH-1:0] tdata;
        logic [LANES-1:0]            tkeep;
        logic                        tlast;
    } word_t;

endpackage

// File: rtl/tmvp_sync_fifo.sv
// First-word-fall-through FIFO with a registered head; DEPTH counts the head slot,
// so the backing memory only ever holds DEPTH-1 entries.
module tmvp_sync_fifo #(
    parameter int WIDTH = 37,
    parameter int DEPTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             head_valid,
    output logic             full
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      mem_count;

    logic pop_ok;
    logic push_ok;
    logic head_free;
    logic mem_has;
    logic mem_pop;
    logic push_to_mem;

    assign full        = head_valid && (mem_count == (AW+1)'(DEPTH - 1));
    assign pop_ok      = pop && head_valid;
    assign push_ok     = push && (!full || pop_ok);
    assign head_free   = !head_valid || pop_ok;
    assign mem_has     = (mem_count != '0);
    assign mem_pop     = head_free && mem_has;
    // An incoming word bypasses the memory only when head and memory are both free.
    assign push_to_mem = push_ok && !(head_free && !mem_has);

    always_ff @(posedge clk) begin
        if (push_to_mem) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            mem_count  <= '0;
            head_valid <= 1'b0;
            head_data  <= '0;
        end else begin
            if (head_free) begin
                if (mem_has) begin
                    head_data  <= mem[rd_ptr];
                    head_valid <= 1'b1;
                    rd_ptr     <= rd_ptr + 1'b1;
                end else if (push_ok) begin
                    head_data  <= push_data;
                    head_valid <= 1'b1;
                end else begin
                    head_valid <= 1'b0;
                end
            end
            if (push_to_mem) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            case ({push_to_mem, mem_pop})
                2'b10:   mem_count <= mem_count + 1'b1;
                2'b01:   mem_count <= mem_count - 1'b1;
                default: mem_count <= mem_count;
            endcase
        end
    end

endmodule

// File: rtl/tmvp_axis_packer.sv
// Packs the unstallable TMVP coefficient stream into LANES-wide AXI4-Stream words,
// buffering them against host backpressure and flagging any dropped word.
module tmvp_axis_packer #(
    parameter int DATA_WIDTH = tmvp_pkg::DATA_WIDTH,
    parameter int REAL_N     = tmvp_pkg::REAL_N,
    parameter int LANES      = tmvp_pkg::LANES,
    parameter int FIFO_DEPTH = 64
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
    input  logic                          s_axis_tvalid,
    output logic [LANES*DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [LANES-1:0]              m_axis_tkeep,
    output logic                          m_axis_tlast,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          overflow,
    output logic                          frame_done,
    output logic [$clog2(REAL_N+1)-1:0]   coef_count
);

    import tmvp_pkg::*;

    localparam int WORD_W = LANES * DATA_WIDTH;
    localparam int BEAT_W = WORD_W + LANES + 1;
    localparam int LW     = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int CW     = $clog2(REAL_N + 1);
    localparam logic [LANES-1:0] FINAL_KEEP = LANES'(keep_mask(REAL_N, LANES));

    typedef struct packed {
        logic [WORD_W-1:0] tdata;
        logic [LANES-1:0]  tkeep;
        logic              tlast;
    } beat_t;

    logic [LW-1:0]     lane_idx;
    logic [WORD_W-1:0] pack_reg;
    logic [WORD_W-1:0] word_next;
    logic              is_last;
    logic              word_done;
    logic              push;
    logic              pop;
    logic              full;
    beat_t             push_beat;
    beat_t             head_beat;

    assign is_last   = (coef_count == CW'(REAL_N - 1));
    assign word_done = is_last || (lane_idx == LW'(LANES - 1));
    assign push      = s_axis_tvalid && word_done;
    assign pop       = m_axis_tvalid && m_axis_tready;

    // Lanes above the current one are still zero because pack_reg clears on every push.
    always_comb begin
        word_next = pack_reg;
        word_next[lane_idx*DATA_WIDTH +: DATA_WIDTH] = s_axis_tdata;
    end

    always_comb begin
        push_beat.tdata = word_next;
        push_beat.tkeep = is_last ? FINAL_KEEP : '1;
        push_beat.tlast = is_last;
    end

    tmvp_sync_fifo #(
        .WIDTH (BEAT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_data  (push_beat),
        .pop        (pop),
        .head_data  (head_beat),
        .head_valid (m_axis_tvalid),
        .full       (full)
    );

    assign m_axis_tdata = head_beat.tdata;
    assign m_axis_tkeep = head_beat.tkeep;
    assign m_axis_tlast = head_beat.tlast;

    // Framing advances even when the word is dropped, so later frames stay aligned.
    always_ff @(posedge clk) begin
        if (!reset) begin
            lane_idx   <= '0;
            coef_count <= '0;
            pack_reg   <= '0;
            overflow   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= pop && head_beat.tlast;
            if (push && full && !pop) begin
                overflow <= 1'b1;
            end
            if (s_axis_tvalid) begin
                pack_reg <= word_done ? '0 : word_next;
                if (is_last) begin
                    lane_idx   <= '0;
                    coef_count <= '0;
                end else begin
                    lane_idx   <= word_done ? '0 : lane_idx + 1'b1;
                    coef_count <= coef_count + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_tmvp_axis_packer.sv
// Directed-sequence bench for tmvp_axis_packer: random and patterned streams are checked
// every cycle against a queue-based model of the frame packing and bounded word buffer.
module tb_tmvp_axis_packer;

    import tmvp_pkg::*;

    localparam int FIFO_DEPTH = 64;
    localparam int CW = $clog2(REAL_N + 1);

    logic                        clk;
    logic                        reset;
    logic [DATA_WIDTH-1:0]       s_axis_tdata;
    logic                        s_axis_tvalid;
    logic [LANES*DATA_WIDTH-1:0] m_axis_tdata;
    logic [LANES-1:0]            m_axis_tkeep;
    logic                        m_axis_tlast;
    logic                        m_axis_tvalid;
    logic                        m_axis_tready;
    logic                        overflow;
    logic                        frame_done;
    logic [CW-1:0]               coef_count;

    tmvp_axis_packer #(
        .DATA_WIDTH (DATA_WIDTH),
        .REAL_N     (REAL_N),
        .LANES      (LANES),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .overflow      (overflow),
        .frame_done    (frame_done),
        .coef_count    (coef_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int failures;
    int fd_seen;

    word_t                 mq[$];
    logic [DATA_WIDTH-1:0] cur[$];
    int                    pos;
    bit                    m_ovf;
    bit                    m_fd;

    word_t                 rx[$];
    logic [DATA_WIDTH-1:0] stream[$];

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic word_t getRx(input int i);
        word_t w;
        w = '0;
        if (i < rx.size()) w = rx[i];
        return w;
    endfunction

    task automatic clearCapture();
        rx.delete();
        stream.delete();
        fd_seen = 0;
    endtask

    // Reference model: bytes gather into frame-relative words; the buffer holds FIFO_DEPTH words.
    task automatic modelEdge(input bit v, input logic [DATA_WIDTH-1:0] d, input bit r);
        word_t w;
        bit    pop;
        if (!reset) begin
            mq.delete();
            cur.delete();
            pos   = 0;
            m_ovf = 0;
            m_fd  = 0;
        end else begin
            pop  = (mq.size() > 0) && r;
            m_fd = 0;
            if (pop) begin
                m_fd = mq[0].tlast;
                void'(mq.pop_front());
            end
            if (v) begin
                cur.push_back(d);
                stream.push_back(d);
                if (cur.size() == LANES || pos == REAL_N - 1) begin
                    w = '0;
                    foreach (cur[k]) w.tdata[k*DATA_WIDTH +: DATA_WIDTH] = cur[k];
                    w.tkeep = LANES'((1 << cur.size()) - 1);
                    w.tlast = (pos == REAL_N - 1);
                    if (mq.size() < FIFO_DEPTH) mq.push_back(w);
                    else m_ovf = 1;
                    cur.delete();
                end
                pos = (pos == REAL_N - 1) ? 0 : pos + 1;
            end
        end
    endtask

    task automatic checkOutput();
        checkVal("tvalid", 64'(m_axis_tvalid), 64'(mq.size() != 0));
        if (mq.size() != 0) begin
            checkVal("tdata", 64'(m_axis_tdata), 64'(mq[0].tdata));
            checkVal("tkeep", 64'(m_axis_tkeep), 64'(mq[0].tkeep));
            checkVal("tlast", 64'(m_axis_tlast), 64'(mq[0].tlast));
        end
        checkVal("overflow", 64'(overflow), 64'(m_ovf));
        checkVal("frame_done", 64'(frame_done), 64'(m_fd));
        checkVal("coef_count", 64'(coef_count), 64'(pos));
        if (frame_done) fd_seen++;
    endtask

    task automatic applyStimulus(input bit v, input logic [DATA_WIDTH-1:0] d, input bit r);
        s_axis_tvalid = v;
        s_axis_tdata  = d;
        m_axis_tready = r;
        if (m_axis_tvalid && r) rx.push_back('{tdata: m_axis_tdata, tkeep: m_axis_tkeep, tlast: m_axis_tlast});
        @(posedge clk);
        #1;
        modelEdge(v, d, r);
        checkOutput();
    endtask

    // Frame built from bytes i mod 256, derived directly from the word/lane rules.
    task automatic checkCountingFrame(input string tag);
        logic [LANES*DATA_WIDTH-1:0] e;
        logic [LANES-1:0]            ek;
        word_t                       w;
        int                          n;
        checkVal({tag, "_words"}, 64'(rx.size()), 64'(WORDS_PER_FRAME));
        for (int i = 0; i < WORDS_PER_FRAME && i < rx.size(); i++) begin
            e = '0;
            for (int k = 0; k < LANES; k++)
                if (i * LANES + k < REAL_N) e[k*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'((i * LANES + k) % 256);
            n  = (REAL_N - i * LANES < LANES) ? REAL_N - i * LANES : LANES;
            ek = LANES'((1 << n) - 1);
            w  = rx[i];
            checkVal({tag, "_data"}, 64'(w.tdata), 64'(e));
            checkVal({tag, "_keep"}, 64'(w.tkeep), 64'(ek));
            checkVal({tag, "_last"}, 64'(w.tlast), 64'(i == WORDS_PER_FRAME - 1));
        end
        w = getRx(0);
        checkVal({tag, "_w0"}, 64'(w.tdata), 64'h03020100);
        w = getRx(126);
        checkVal({tag, "_w126"}, 64'(w.tdata), 64'hFBFAF9F8);
        w = getRx(127);
        checkVal({tag, "_w127_data"}, 64'(w.tdata), 64'h000000FC);
        checkVal({tag, "_w127_keep"}, 64'(w.tkeep), 64'h1);
        checkVal({tag, "_w127_last"}, 64'(w.tlast), 64'h1);
        checkVal({tag, "_frame_done"}, 64'(fd_seen), 64'd1);
        checkVal({tag, "_overflow"}, 64'(overflow), 64'd0);
    endtask

    initial begin
        word_t w;
        checks   = 0;
        failures = 0;
        fd_seen  = 0;
        pos      = 0;
        m_ovf    = 0;
        m_fd     = 0;
        reset = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        m_axis_tready = 1'b0;

        $display("[TB] reset state");
        repeat (3) applyStimulus(1'b1, 8'hAA, 1'b0);
        checkVal("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        checkVal("rst_tdata", 64'(m_axis_tdata), 64'd0);
        checkVal("rst_tkeep", 64'(m_axis_tkeep), 64'd0);
        checkVal("rst_tlast", 64'(m_axis_tlast), 64'd0);
        checkVal("rst_overflow", 64'(overflow), 64'd0);
        checkVal("rst_frame_done", 64'(frame_done), 64'd0);
        checkVal("rst_coef_count", 64'(coef_count), 64'd0);
        reset = 1'b1;

        $display("[TB] continuous counting frame");
        clearCapture();
        for (int i = 0; i < REAL_N; i++) applyStimulus(1'b1, 8'(i % 256), 1'b1);
        repeat (10) applyStimulus(1'b0, 8'h00, 1'b1);
        checkCountingFrame("cont");

        $display("[TB] one-in-three counting frame");
        clearCapture();
        for (int c = 0; c < REAL_N * 3; c++) applyStimulus(c % 3 == 0, 8'((c / 3) % 256), 1'b1);
        repeat (10) applyStimulus(1'b0, 8'h00, 1'b1);
        checkCountingFrame("sparse");

        $display("[TB] stalled sink");
        clearCapture();
        for (int i = 0; i < 300; i++) applyStimulus(1'b1, 8'($urandom), 1'b0);
        checkVal("stall_overflow", 64'(overflow), 64'd1);
        for (int i = 300; i < REAL_N; i++) applyStimulus(1'b1, 8'($urandom), 1'b1);
        repeat (80) applyStimulus(1'b0, 8'h00, 1'b1);
        checkVal("stall_words", 64'(rx.size()), 64'(WORDS_PER_FRAME - 11));
        w = getRx(63);
        checkVal("stall_w63", 64'(w.tdata), 64'({stream[255], stream[254], stream[253], stream[252]}));
        w = getRx(WORDS_PER_FRAME - 12);
        checkVal("stall_last_flag", 64'(w.tlast), 64'd1);
        checkVal("stall_last_byte", 64'(w.tdata), 64'(stream[REAL_N-1]));
        checkVal("stall_sticky", 64'(overflow), 64'd1);

        $display("[TB] random backpressure");
        reset = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0);
        reset = 1'b1;
        clearCapture();
        for (int c = 0; c < REAL_N * 2; c++) applyStimulus(c % 2 == 0, 8'($urandom), 1'($urandom));
        repeat (100) applyStimulus(1'b0, 8'h00, 1'($urandom));
        repeat (80) applyStimulus(1'b0, 8'h00, 1'b1);
        checkVal("bp_words", 64'(rx.size()), 64'(WORDS_PER_FRAME));
        w = getRx(WORDS_PER_FRAME - 1);
        checkVal("bp_last", 64'(w.tlast), 64'd1);
        checkVal("bp_overflow", 64'(overflow), 64'd0);

        $display("[TB] mid-frame reset");
        for (int i = 0; i < 100; i++) applyStimulus(1'b1, 8'($urandom), 1'b1);
        reset = 1'b0;
        applyStimulus(1'b1, 8'h5A, 1'b1);
        checkVal("mid_tvalid", 64'(m_axis_tvalid), 64'd0);
        checkVal("mid_coef_count", 64'(coef_count), 64'd0);
        checkVal("mid_overflow", 64'(overflow), 64'd0);
        reset = 1'b1;
        clearCapture();
        for (int i = 0; i < REAL_N; i++) applyStimulus(1'b1, 8'($urandom), 1'b1);
        repeat (10) applyStimulus(1'b0, 8'h00, 1'b1);
        w = getRx(0);
        checkVal("mid_w0", 64'(w.tdata), 64'({stream[3], stream[2], stream[1], stream[0]}));
        checkVal("mid_words", 64'(rx.size()), 64'(WORDS_PER_FRAME));

        $display("[TB] back-to-back frames");
        clearCapture();
        for (int i = 0; i < REAL_N * 2; i++) applyStimulus(1'b1, 8'($urandom), 1'b1);
        repeat (10) applyStimulus(1'b0, 8'h00, 1'b1);
        checkVal("b2b_words", 64'(rx.size()), 64'(2 * WORDS_PER_FRAME));
        w = getRx(WORDS_PER_FRAME - 1);
        checkVal("b2b_last1", 64'(w.tlast), 64'd1);
        w = getRx(2 * WORDS_PER_FRAME - 1);
        checkVal("b2b_last2", 64'(w.tlast), 64'd1);
        w = getRx(WORDS_PER_FRAME);
        checkVal("b2b_w128_lane0", 64'(w.tdata[DATA_WIDTH-1:0]), 64'(stream[REAL_N]));
        checkVal("b2b_w128_last", 64'(w.tlast), 64'd0);
        checkVal("b2b_frame_done", 64'(fd_seen), 64'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
